// File: rtl/pipeline_front_regs.sv
// pipeline_front_regs: PC, IF/ID and ID/EX registers with stall, squash, flush and bubble counting
module pipeline_front_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushE,
    input  logic        PCSrcD,
    input  logic        jumpD,
    input  logic [31:0] PCBranchD,
    input  logic [31:0] JumpTargetD,
    input  logic [31:0] InstrF,
    input  logic        RegWriteD,
    input  logic        MemtoRegD,
    input  logic        MemWriteD,
    input  logic        ALUSrcD,
    input  logic        RegDstD,
    input  logic [2:0]  ALUControlD,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    input  logic [31:0] SignImmD,
    input  logic [4:0]  RsD,
    input  logic [4:0]  RtD,
    input  logic [4:0]  RdD,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        ValidE,
    output logic        RegWriteE,
    output logic        MemtoRegE,
    output logic        MemWriteE,
    output logic        ALUSrcE,
    output logic        RegDstE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] SignImmE,
    output logic [4:0]  RsE,
    output logic [4:0]  RtE,
    output logic [4:0]  RdE,
    output logic [15:0] BubbleCountE
);
    localparam int EW = 119;
    logic [31:0]   pcf_q, pcf_d, pc_plus4_f;
    logic [31:0]   instr_d_q, instr_d_d, pc_plus4_d_q, pc_plus4_d_d;
    logic          valid_d_q, valid_d_d, valid_e_q, valid_e_d, redirect;
    logic [EW-1:0] ex_q, ex_d;
    logic [15:0]   bubble_cnt_q, bubble_cnt_d;
    always_comb begin
        pc_plus4_f   = pcf_q + 32'd4;
        redirect     = PCSrcD | jumpD;
        // a stalled fetch ignores redirects: branch operands are not valid yet
        pcf_d        = StallF ? pcf_q : jumpD ? JumpTargetD : PCSrcD ? PCBranchD : pc_plus4_f;
        instr_d_d    = StallD ? instr_d_q : redirect ? NOP_INSTR : InstrF;
        pc_plus4_d_d = StallD ? pc_plus4_d_q : redirect ? 32'd0 : pc_plus4_f;
        valid_d_d    = StallD ? valid_d_q : !redirect;
        ex_d         = FlushE ? '0 : {RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD,
                                      ALUControlD, RD1D, RD2D, SignImmD, RsD, RtD, RdD};
        valid_e_d    = !FlushE && valid_d_q;
        bubble_cnt_d = (!valid_e_d && bubble_cnt_q != 16'hFFFF) ? bubble_cnt_q + 16'd1 : bubble_cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q        <= RESET_PC;
            instr_d_q    <= NOP_INSTR;
            pc_plus4_d_q <= '0;
            valid_d_q    <= 1'b0;
            valid_e_q    <= 1'b0;
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pcf_q        <= pcf_d;
            instr_d_q    <= instr_d_d;
            pc_plus4_d_q <= pc_plus4_d_d;
            valid_d_q    <= valid_d_d;
            valid_e_q    <= valid_e_d;
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end
    assign PCF          = pcf_q;
    assign InstrD       = instr_d_q;
    assign PCPlus4D     = pc_plus4_d_q;
    assign ValidD       = valid_d_q;
    assign ValidE       = valid_e_q;
    assign BubbleCountE = bubble_cnt_q;
    assign {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE,
            ALUControlE, RD1E, RD2E, SignImmE, RsE, RtE, RdE} = ex_q;
endmodule

// File: doc/pipeline_front_regs.md
# pipeline_front_regs

Front-end state holder for the 5-stage pipelined MIPS core. It holds the PC register, the IF/ID register and the ID/EX register, and it applies the StallF, StallD and FlushE decisions made by the hazard unit. It also squashes wrong-path fetches on taken branches and jumps, tracks a valid bit per stage, and counts bubbles injected into Execute for performance monitoring. It sits between the instruction memory and register file on one side and the execute datapath on the other.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, encoding written into InstrD on reset and squash
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold the IF/ID register
- FlushE  in  1  load a bubble into the ID/EX register
- PCSrcD  in  1  taken branch resolved in Decode
- jumpD  in  1  jump in Decode
- PCBranchD  in  32  branch target
- JumpTargetD  in  32  jump target
- InstrF  in  32  instruction memory read data for PCF
- RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD  in  1 each  decode control
- ALUControlD  in  3  ALU operation
- RD1D, RD2D, SignImmD  in  32 each  decode operands
- RsD, RtD, RdD  in  5 each  register specifiers
- PCF  out  32  current fetch PC
- InstrD, PCPlus4D  out  32 each  IF/ID contents
- ValidD, ValidE  out  1 each  stage holds a real instruction
- RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE  out  1 each  ID/EX control
- ALUControlE  out  3  ID/EX ALU operation
- RD1E, RD2E, SignImmE  out  32 each  ID/EX operands
- RsE, RtE, RdE  out  5 each  ID/EX specifiers
- BubbleCountE  out  16  saturating count of bubbles entering Execute

## Operation
- PCPlus4F = PCF + 4, computed internally, modulo 2^32. 0xFFFF_FFFC wraps to 0.
- Next-PC priority: jumpD selects JumpTargetD; otherwise PCSrcD selects PCBranchD; otherwise PCPlus4F.
  - If jumpD and PCSrcD are asserted together, jumpD wins.
- PC register, in priority order:
  - reset: load RESET_PC.
  - StallF=1: hold PCF. Any redirect is ignored, because branch operands are not yet valid under a branch stall.
  - Otherwise: load next-PC.
- IF/ID register, in priority order:
  - reset: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - StallD=1: hold all fields.
  - PCSrcD or jumpD: squash with InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0.
  - Otherwise: InstrD=InstrF, PCPlus4D=PCPlus4F, ValidD=1.
- ID/EX register, in priority order. It has no stall input.
  - reset or FlushE: every control, operand and specifier field is 0, and ValidE=0.
  - Otherwise: every E field is loaded from the corresponding D field, and ValidE=ValidD.
- A bubble is counted on any rising edge where ID/EX loads ValidE=0 and reset is low. This covers both FlushE and a squashed ValidD.
  - BubbleCountE increments by 1 and saturates at 16'hFFFF.
  - Reset clears BubbleCountE to 0.
- Reset values: PCF=RESET_PC; InstrD=NOP_INSTR; every other output is 0.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Fetch-to-Decode latency is 1 cycle. Decode-to-Execute latency is 1 cycle.
- A redirect is visible in PCF one cycle after PCSrcD or jumpD, provided StallF=0.
- A taken branch or jump costs one squashed slot. The fetched instruction is converted to NOP in IF/ID.
- StallD=1 together with FlushE=1 (lwstall or branchstall): D holds and E receives a bubble in the same edge. The stalled instruction re-enters E on the first edge after the stall releases.
- Reset asserted mid-stall or mid-redirect overrides everything on that edge.
- Inputs are sampled only at the rising edge. Glitches between edges have no effect.

## Test plan
- **Reset:** assert reset for 2 cycles with stalls and redirects active -> PCF=0x0040_0000, InstrD=0, ValidD=0, ValidE=0, BubbleCountE=0.
- **Straight-line fetch:** InstrF=0x2008_0005, then 0x2009_0003, no hazards -> PCF reads 0x0040_0004 then 0x0040_0008. InstrD=0x2008_0005 with PCPlus4D=0x0040_0004. ValidE=1 two cycles after the first fetch.
- **Load-use stall:** StallF=StallD=FlushE=1 for 1 cycle -> PCF and InstrD unchanged, RegWriteE=0, ValidE=0, BubbleCountE=1. The next cycle resumes with the held instruction in E.
- **Taken branch:** PCSrcD=1, PCBranchD=0x0040_0040 -> next PCF=0x0040_0040, InstrD=NOP_INSTR, ValidD=0. The following edge gives ValidE=0 and BubbleCountE increments.
- **Branch under branchstall:** StallF=StallD=FlushE=1 with PCSrcD=1 and PCBranchD=0x0040_0080 -> PCF held, InstrD held, no redirect taken.
- **Priority and wrap:**
  - jumpD=1 and PCSrcD=1 with JumpTargetD=0x0040_0100 and PCBranchD=0x0040_0200 -> PCF=0x0040_0100.
  - PCF=0xFFFF_FFFC with no redirect -> PCF=0x0000_0000.
  - Force 65,536 consecutive bubbles -> BubbleCountE stays at 0xFFFF.
